bcd_7seg_scanner: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits. The block latches a packed multi-digit BCD word plus per-digit decimal points on a load strobe. It scans one digit at a time at a programmable slot rate and drives shared active-low segment lines. It adds leading-zero blanking, a one-cycle anti-ghosting gap between digits, and a dash glyph for non-BCD codes. It sits between the counter/arithmetic datapath and the board display pins.

---
 rtl/bcd_7seg_scanner.sv | 152 +++++++++++++++
 tb/tb_bcd_7seg_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: time-multiplexed driver for a bank of common-anode
// seven-segment digits. It holds a shadow copy of the BCD word and the decimal
// points, and it scans one digit per slot of DIV cycles. Each slot opens with
// one guard cycle where all anodes are off. Codes that are not BCD show a dash,
// and leading zeros can be blanked. All outputs are registered.
module bcd_7seg_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   bcd_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   input  logic                      enable,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     an_out,
   output logic [IDX_W-1:0]          digit_idx
);

   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [4*NUM_DIGITS-1:0] sh_bcd;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              sel_code;
   logic                    sel_blank;
   logic                    sel_dp;
   logic [6:0]              glyph;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   // Shadow registers: capture the display word on load, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_bcd <= '0;
         sh_dp  <= '0;
      end else if (load) begin
         sh_bcd <= bcd_in;
         sh_dp  <= dp_in;
      end
   end

   // Next slot counter and digit index. Both freeze while enable is low.
   always_comb begin
      cnt_nxt = cnt;
      idx_nxt = idx;
      if (enable) begin
         if (cnt == CNT_W'(DIV - 1)) begin
            cnt_nxt = '0;
            if (idx == IDX_W'(NUM_DIGITS - 1))
               idx_nxt = '0;
            else
               idx_nxt = idx + 1'b1;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // Slot counter and digit index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt_nxt;
         idx <= idx_nxt;
      end
   end

   // Leading-zero mask. Walk down from the top digit while every digit so far
   // is zero. Digit 0 is never blanked.
   always_comb begin
      logic all_zero;
      int unsigned i;
      lz_blank = '0;
      all_zero = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         i = NUM_DIGITS - 1 - k;
         all_zero = all_zero && (sh_bcd[4*i +: 4] == 4'd0);
         lz_blank[i] = blank_lz && (i > 0) && all_zero;
      end
   end

   // Select the digit addressed by the post-edge index.
   always_comb begin
      sel_code  = '0;
      sel_blank = 1'b0;
      sel_dp    = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_nxt == IDX_W'(i)) begin
            sel_code  = sh_bcd[4*i +: 4];
            sel_blank = lz_blank[i];
            sel_dp    = sh_dp[i];
         end
      end
   end

   // Active-low glyph decode {g,f,e,d,c,b,a}. Non-BCD codes show a dash.
   always_comb begin
      glyph = 7'b0111111;
      case (sel_code)
         4'd0: glyph = 7'b1000000;
         4'd1: glyph = 7'b1111001;
         4'd2: glyph = 7'b0100100;
         4'd3: glyph = 7'b0110000;
         4'd4: glyph = 7'b0011001;
         4'd5: glyph = 7'b0010010;
         4'd6: glyph = 7'b0000010;
         4'd7: glyph = 7'b1111000;
         4'd8: glyph = 7'b0000000;
         4'd9: glyph = 7'b0010000;
         default: glyph = 7'b0111111;
      endcase
   end

   // Output values from post-edge counter state. The guard cycle (cnt==0)
   // and the disabled state blank everything.
   always_comb begin
      an_nxt  = '1;
      seg_nxt = '1;
      dp_nxt  = 1'b1;
      if (enable && (cnt_nxt != '0)) begin
         an_nxt[idx_nxt] = 1'b0;
         seg_nxt         = sel_blank ? 7'b1111111 : glyph;
         dp_nxt          = ~sel_dp;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out   <= '1;
         dp_out    <= 1'b1;
         an_out    <= '1;
         digit_idx <= '0;
      end else begin
         seg_out   <= seg_nxt;
         dp_out    <= dp_nxt;
         an_out    <= an_nxt;
         digit_idx <= idx_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Testbench for bcd_7seg_scanner. It runs directed scenes and then random
// traffic, and it compares every cycle against a frame-position reference model.
module tb_bcd_7seg_scanner;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            load;
   logic [4*N-1:0]  bcd_in;
   logic [N-1:0]    dp_in;
   logic            blank_lz;
   logic            enable;
   logic [6:0]      seg_out;
   logic            dp_out;
   logic [N-1:0]    an_out;
   logic [1:0]      digit_idx;

   bcd_7seg_scanner #(.NUM_DIGITS(N), .DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .bcd_in    (bcd_in),
      .dp_in     (dp_in),
      .blank_lz  (blank_lz),
      .enable    (enable),
      .seg_out   (seg_out),
      .dp_out    (dp_out),
      .an_out    (an_out),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Model state: position within the frame in enabled cycles, plus the shadow word.
   int unsigned pos;
   int unsigned m_bcd;
   int unsigned m_dp;
   logic [6:0]  glyph_tab [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int unsigned digit_of(input int unsigned word, input int unsigned i);
      return (word / (16 ** i)) % 16;
   endfunction

   // One clock: update the model for this edge, then compare just after the edge.
   task automatic tick();
      int unsigned d, code;
      bit          lit, blanked;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic [N-1:0] e_an;
      @(posedge clk);
      if (enable) pos = (pos + 1) % (N * DIV);
      d   = pos / DIV;
      lit = enable && (pos % DIV != 0);
      code    = digit_of(m_bcd, d);
      blanked = blank_lz && (d > 0) && ((m_bcd / (16 ** d)) == 0);
      e_an  = '1;
      e_seg = 7'h7f;
      e_dp  = 1'b1;
      if (lit) begin
         e_an[d] = 1'b0;
         e_seg   = blanked ? 7'h7f : glyph_tab[code];
         e_dp    = ((m_dp >> d) & 1) == 0;
      end
      if (load) begin
         m_bcd = 32'(bcd_in);
         m_dp  = 32'(dp_in);
      end
      #1;
      check("an",  32'(an_out),    32'(e_an));
      check("seg", 32'(seg_out),   32'(e_seg));
      check("dp",  32'(dp_out),    32'(e_dp));
      check("idx", 32'(digit_idx), 32'(d));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seg"}, 32'(seg_out),   32'h7f);
      check({tag, "_dp"},  32'(dp_out),    32'h1);
      check({tag, "_an"},  32'(an_out),    32'hf);
      check({tag, "_idx"}, 32'(digit_idx), 32'h0);
   endtask

   task automatic show(input logic [15:0] word, input logic [3:0] dps,
                       input logic blz, input int unsigned cycles);
      blank_lz = blz;
      bcd_in   = word;
      dp_in    = dps;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      for (int k = 0; k < cycles; k++) tick();
   endtask

   initial begin
      glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
      blank_lz = 1'b0; enable = 1'b0;
      pos = 0; m_bcd = 0; m_dp = 0;
      #12;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      enable = 1'b1;

      // Directed display scenes.
      show(16'h1234, 4'b0000, 1'b0, 20);
      show(16'h0070, 4'b0000, 1'b1, 18);
      show(16'h0000, 4'b0000, 1'b1, 17);
      show(16'h0A05, 4'b0000, 1'b1, 16);
      show(16'h0003, 4'b0100, 1'b1, 16);

      // Load in the middle of the digit-0 slot, changing 5 to 9.
      show(16'h0005, 4'b0000, 1'b0, 0);
      while (pos != 2) tick();
      bcd_in = 16'h0009; load = 1'b1;
      tick();
      load = 1'b0;
      tick(); tick();

      // Freeze at cnt=2 of slot 1, then resume.
      while (pos != DIV + 2) tick();
      enable = 1'b0;
      tick(); tick(); tick();
      enable = 1'b1;
      for (int k = 0; k < 8; k++) tick();

      // Asynchronous reset in the middle of a slot, with no clock edge.
      show(16'h9876, 4'b1010, 1'b0, 5);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      pos = 0; m_bcd = 0; m_dp = 0;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) tick();

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         logic [15:0] w;
         int unsigned top_zero;
         w = '0;
         for (int i = 0; i < N; i++) begin
            logic [3:0] dg;
            dg = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            w[4*i +: 4] = dg;
         end
         top_zero = $urandom_range(0, N);
         for (int i = 0; i < N; i++)
            if (i >= N - int'(top_zero)) w[4*i +: 4] = 4'd0;
         bcd_in   = w;
         dp_in    = 4'($urandom);
         load     = ($urandom_range(0, 3) == 0);
         enable   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
